// File: rtl/warning_dispatch_arbiter.sv
// warning_dispatch_arbiter
// Shares one pager channel among several patient monitors. Each patient's warning
// is latched, aged and escalated while it waits. One alarm at a time is offered over
// a valid/ready handshake. The highest level wins, and equal levels are served
// round-robin starting after the most recently granted patient.
module warning_dispatch_arbiter #(
    parameter int NUM_PATIENTS    = 4,
    parameter int ESCALATE_CYCLES = 16,
    parameter int PW              = $clog2(NUM_PATIENTS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [3*NUM_PATIENTS-1:0]   patientWarning,
    input  logic                        dispatchReady,
    output logic                        dispatchValid,
    output logic [PW-1:0]               dispatchPatient,
    output logic [2:0]                  dispatchLevel,
    output logic [NUM_PATIENTS-1:0]     pendingMask
);

    localparam int                AW       = (ESCALATE_CYCLES > 1) ? $clog2(ESCALATE_CYCLES) : 1;
    localparam logic [AW-1:0]     AGE_LAST = AW'(ESCALATE_CYCLES - 1);
    localparam logic [PW-1:0]     LAST_IDX = PW'(NUM_PATIENTS - 1);
    localparam logic [PW:0]       NUM_WIDE = (PW+1)'(NUM_PATIENTS);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t                     r_state;
    state_t                     w_nextState;

    logic [NUM_PATIENTS-1:0]    r_pending;
    logic [NUM_PATIENTS-1:0]    r_armed;
    logic [2:0]                 r_level [NUM_PATIENTS];
    logic [AW-1:0]              r_age   [NUM_PATIENTS];

    logic [NUM_PATIENTS-1:0]    w_nextPending;
    logic [NUM_PATIENTS-1:0]    w_nextArmed;
    logic [2:0]                 w_nextLevel [NUM_PATIENTS];
    logic [AW-1:0]              w_nextAge   [NUM_PATIENTS];

    logic [2:0]                 w_input  [NUM_PATIENTS];
    logic [2:0]                 w_raised [NUM_PATIENTS];
    logic [2:0]                 w_bumped [NUM_PATIENTS];
    logic [NUM_PATIENTS-1:0]    w_offered;

    logic [PW-1:0]              r_lastGrant;
    logic [PW-1:0]              r_dispatchPatient;
    logic [2:0]                 r_dispatchLevel;

    logic [PW-1:0]              w_winner;
    logic [2:0]                 w_winnerLevel;
    logic [PW:0]                w_scan;
    logic [PW-1:0]              w_scanIdx;

    logic                       w_load;
    logic                       w_xfer;

    // Split the packed input bus per patient and precompute the raised and escalated level candidates
    always_comb begin
        for (int i = 0; i < NUM_PATIENTS; i++) begin
            w_input[i]  = patientWarning[3*i +: 3];
            w_raised[i] = (w_input[i] > r_level[i]) ? w_input[i] : r_level[i];
            w_bumped[i] = (r_level[i] == 3'd7) ? 3'd7 : r_level[i] + 3'd1;
            if (w_input[i] > w_bumped[i]) begin
                w_bumped[i] = w_input[i];
            end
        end
    end

    // One-hot marker of the patient currently on offer; it is frozen against escalation
    always_comb begin
        w_offered = '0;
        if (r_state == OFFER) begin
            w_offered[r_dispatchPatient] = 1'b1;
        end
    end

    // Scan upward from the last grant and keep the first patient holding a strictly higher level
    always_comb begin
        w_winner      = '0;
        w_winnerLevel = '0;
        w_scan        = '0;
        w_scanIdx     = '0;
        for (int k = 1; k <= NUM_PATIENTS; k++) begin
            w_scan = {1'b0, r_lastGrant} + (PW+1)'(k);
            if (w_scan >= NUM_WIDE) begin
                w_scan = w_scan - NUM_WIDE;
            end
            w_scanIdx = w_scan[PW-1:0];
            if (r_pending[w_scanIdx] && (r_level[w_scanIdx] > w_winnerLevel)) begin
                w_winner      = w_scanIdx;
                w_winnerLevel = r_level[w_scanIdx];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state: offer whenever something is pending, and leave only on a completed transfer
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (|r_pending)   w_nextState = OFFER;
            OFFER:   if (dispatchReady) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // FSM outputs: load the winner on leaving IDLE, and complete a transfer on ready during OFFER
    always_comb begin
        w_load        = (r_state == IDLE) && (|r_pending);
        w_xfer        = (r_state == OFFER) && dispatchReady;
        dispatchValid = (r_state == OFFER);
    end

    // Per-patient latch, re-arm, escalation and transfer bookkeeping
    always_comb begin
        for (int i = 0; i < NUM_PATIENTS; i++) begin
            w_nextPending[i] = r_pending[i];
            w_nextArmed[i]   = r_armed[i];
            w_nextLevel[i]   = r_level[i];
            w_nextAge[i]     = r_age[i];

            if (w_input[i] == 3'd0) begin
                w_nextArmed[i] = 1'b1;
            end

            if (w_offered[i] && dispatchReady) begin
                w_nextArmed[i] = 1'b0;
                w_nextAge[i]   = '0;
                if (w_raised[i] <= r_dispatchLevel) begin
                    w_nextPending[i] = 1'b0;
                    w_nextLevel[i]   = 3'd0;
                end else begin
                    w_nextLevel[i]   = w_raised[i];
                end
            end else if (r_pending[i]) begin
                if (w_offered[i] || (r_level[i] == 3'd7)) begin
                    w_nextLevel[i] = w_raised[i];
                end else if (r_age[i] == AGE_LAST) begin
                    w_nextLevel[i] = w_bumped[i];
                    w_nextAge[i]   = '0;
                end else begin
                    w_nextLevel[i] = w_raised[i];
                    w_nextAge[i]   = r_age[i] + AW'(1);
                end
                if (w_nextLevel[i] == 3'd7) begin
                    w_nextAge[i] = '0;
                end
            end else if (r_armed[i] && (w_input[i] != 3'd0)) begin
                w_nextPending[i] = 1'b1;
                w_nextLevel[i]   = w_input[i];
                w_nextAge[i]     = '0;
            end
        end
    end

    // Per-patient state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= '0;
            r_armed   <= '1;
            for (int i = 0; i < NUM_PATIENTS; i++) begin
                r_level[i] <= 3'd0;
                r_age[i]   <= '0;
            end
        end else begin
            r_pending <= w_nextPending;
            r_armed   <= w_nextArmed;
            for (int i = 0; i < NUM_PATIENTS; i++) begin
                r_level[i] <= w_nextLevel[i];
                r_age[i]   <= w_nextAge[i];
            end
        end
    end

    // Offer registers and round-robin pointer; reset points at the last patient so patient 0 wins first
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dispatchPatient <= '0;
            r_dispatchLevel   <= 3'd0;
            r_lastGrant       <= LAST_IDX;
        end else begin
            if (w_load) begin
                r_dispatchPatient <= w_winner;
                r_dispatchLevel   <= w_winnerLevel;
            end
            if (w_xfer) begin
                r_lastGrant <= r_dispatchPatient;
            end
        end
    end

    assign dispatchPatient = r_dispatchPatient;
    assign dispatchLevel   = r_dispatchLevel;
    assign pendingMask     = r_pending;

endmodule
